// File: rtl/inv_mix_column_pkg.sv
// Shared types and constants for the AES inverse column mix block.
package inv_mix_column_pkg;

    typedef enum logic [1:0] {
        LOAD,
        CALC,
        OUT
    } state_e;

    typedef enum logic [1:0] {
        MUL_09,
        MUL_0B,
        MUL_0D,
        MUL_0E
    } mul_sel_e;

    localparam logic [7:0] GF_RED = 8'h1B;

    localparam logic [7:0] INV_ROW [4] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? GF_RED : 8'h00);
    endfunction

    function automatic mul_sel_e coef_sel(input logic [7:0] c);
        mul_sel_e s;
        case (c)
            8'h0B:   s = MUL_0B;
            8'h0D:   s = MUL_0D;
            8'h0E:   s = MUL_0E;
            default: s = MUL_09;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/inv_mix_column_gf_mul_const.sv
// Multiply a byte by one of the inverse-row constants in GF(2^8),
// built from a shared xtime chain.
module gf_mul_const
    import inv_mix_column_pkg::*;
(
    input  logic [7:0] v_i,
    input  mul_sel_e   sel_i,
    output logic [7:0] p_o
);

    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;

    assign x2 = xtime(v_i);
    assign x4 = xtime(x2);
    assign x8 = xtime(x4);

    always_comb begin
        p_o = '0;
        unique case (sel_i)
            MUL_09: p_o = x8 ^ v_i;
            MUL_0B: p_o = x8 ^ x2 ^ v_i;
            MUL_0D: p_o = x8 ^ x4 ^ v_i;
            MUL_0E: p_o = x8 ^ x4 ^ x2;
        endcase
    end

endmodule

// File: rtl/inv_mix_column.sv
// Byte-serial AES inverse MixColumns: load four bytes, compute
// one result byte per cycle, then stream the column out.
module inv_mix_column
    import inv_mix_column_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_byte,
    input  logic       out_ready,
    output logic       busy
);

    state_e     state_q;
    logic [1:0] cnt_q;
    logic [7:0] a_q [4];
    logic [7:0] b_q [4];
    logic       ov_q;
    logic [7:0] ob_q;

    logic [7:0] prod [4];
    logic [7:0] b_d;

    // Lane j multiplies a[cnt+j] by the j-th row coefficient.
    for (genvar j = 0; j < 4; j++) begin : g_mul
        logic [1:0] idx;
        assign idx = cnt_q + 2'(j);
        gf_mul_const u_mul (
            .v_i   (a_q[idx]),
            .sel_i (coef_sel(INV_ROW[j])),
            .p_o   (prod[j])
        );
    end

    assign b_d = prod[0] ^ prod[1] ^ prod[2] ^ prod[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            ob_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        a_q[cnt_q] <= in_byte;
                        cnt_q      <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) state_q <= CALC;
                    end
                end
                CALC: begin
                    b_q[cnt_q] <= b_d;
                    cnt_q      <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_q <= OUT;
                end
                OUT: begin
                    // First OUT cycle only primes the output register.
                    if (!ov_q) begin
                        ov_q <= 1'b1;
                        ob_q <= b_q[cnt_q];
                    end else if (out_ready) begin
                        if (cnt_q == 2'd3) begin
                            state_q <= LOAD;
                            ov_q    <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                            ob_q  <= b_q[cnt_q + 2'd1];
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != LOAD);
    assign out_valid = ov_q;
    assign out_byte  = ob_q;

endmodule

// File: tb/tb_inv_mix_column.sv
// Randomised and directed bench for inv_mix_column against a
// generic GF(2^8) multiply reference.
module tb_inv_mix_column;

    typedef logic [3:0][7:0] col_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_byte = '0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_byte;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc0_cyc = 0;
    int acc3_cyc = 0;
    int hs_cyc = 0;

    inv_mix_column dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_byte  (out_byte),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] x,
                                        input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] a;
        p = '0;
        a = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
        end
        return p;
    endfunction

    function automatic col_t inv_model(input col_t a);
        logic [7:0] coef [4];
        col_t b;
        coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        for (int i = 0; i < 4; i++) begin
            b[i] = '0;
            for (int j = 0; j < 4; j++)
                b[i] ^= gmul(coef[j], a[(i + j) % 4]);
        end
        return b;
    endfunction

    function automatic col_t mk(input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3);
        col_t c;
        c[0] = b0;
        c[1] = b1;
        c[2] = b2;
        c[3] = b3;
        return c;
    endfunction

    // mode 0: back-to-back, 1: toggling valid, 2: random valid
    task automatic send_col(input col_t c, input int mode);
        int  i;
        int  guard;
        bit  tog;
        bit  acc;
        i = 0;
        guard = 0;
        tog = 1'b1;
        while (i < 4 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (mode == 0) in_valid = 1'b1;
            else if (mode == 1) begin
                in_valid = tog;
                tog = ~tog;
            end else in_valid = 1'($urandom % 2);
            in_byte = in_valid ? c[i] : 8'($urandom);
            if (mode == 0) chk("in_ready_load", 32'(in_ready), 1);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                if (i == 0) acc0_cyc = cyc;
                if (i == 3) acc3_cyc = cyc;
                i++;
            end
        end
        chk("send_done", i, 4);
    endtask

    // mode 0: always ready, 1: stall 3 cycles on b1, 2: random ready
    task automatic recv(input col_t e, input int mode);
        int j;
        int guard;
        int stall;
        bit first;
        bit rdy;
        bit hv;
        j = 0;
        guard = 0;
        stall = (mode == 1) ? 3 : 0;
        first = 1'b1;
        while (j < 4 && guard < 200) begin
            @(negedge clk);
            guard++;
            in_valid = 1'($urandom % 2);
            in_byte = 8'($urandom);
            if (!out_valid) begin
                if (!first) chk("ov_hold", 32'(out_valid), 1);
                chk("in_ready_calc", 32'(in_ready), 0);
                chk("busy_calc", 32'(busy), 1);
                out_ready = 1'($urandom % 2);
            end else begin
                if (first) chk("latency", cyc - acc3_cyc, 5);
                first = 1'b0;
                if (mode == 2) rdy = 1'($urandom % 2);
                else if (mode == 1 && j == 1 && stall > 0) begin
                    rdy = 1'b0;
                    stall--;
                end else rdy = 1'b1;
                out_ready = rdy;
                chk($sformatf("b%0d", j), 32'(out_byte), 32'(e[j]));
                chk("in_ready_out", 32'(in_ready), 0);
                chk("busy_out", 32'(busy), 1);
            end
            hv = out_valid && out_ready;
            @(posedge clk);
            #1;
            if (hv) begin
                if (j == 3) hs_cyc = cyc;
                j++;
            end
        end
        chk("recv_done", j, 4);
        chk("ov_after", 32'(out_valid), 0);
        chk("in_ready_after", 32'(in_ready), 1);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_byte"}, 32'(out_byte), 0);
    endtask

    initial begin
        col_t c;
        col_t e;

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst0");
        @(negedge clk);
        rst = 1'b1;

        send_col(mk(8'h8E, 8'h4D, 8'hA1, 8'hBC), 0);
        recv(mk(8'hDB, 8'h13, 8'h53, 8'h45), 0);
        send_col(mk(8'h9F, 8'hDC, 8'h58, 8'h9D), 0);
        recv(mk(8'hF2, 8'h0A, 8'h22, 8'h5C), 0);
        send_col(mk(8'h01, 8'h01, 8'h01, 8'h01), 0);
        recv(mk(8'h01, 8'h01, 8'h01, 8'h01), 0);
        send_col(mk(8'hC6, 8'hC6, 8'hC6, 8'hC6), 0);
        recv(mk(8'hC6, 8'hC6, 8'hC6, 8'hC6), 0);

        send_col(mk(8'h8E, 8'h4D, 8'hA1, 8'hBC), 1);
        recv(mk(8'hDB, 8'h13, 8'h53, 8'h45), 1);

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte = 8'hA5 + 8'(i);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset("rst1");
        @(negedge clk);
        rst = 1'b1;
        send_col(mk(8'h9F, 8'hDC, 8'h58, 8'h9D), 0);
        recv(mk(8'hF2, 8'h0A, 8'h22, 8'h5C), 0);

        send_col(mk(8'h8E, 8'h4D, 8'hA1, 8'hBC), 0);
        recv(mk(8'hDB, 8'h13, 8'h53, 8'h45), 0);
        send_col(mk(8'h9F, 8'hDC, 8'h58, 8'h9D), 0);
        chk("b2b_a0", acc0_cyc - hs_cyc, 1);
        recv(mk(8'hF2, 8'h0A, 8'h22, 8'h5C), 0);

        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 4; i++) c[i] = 8'($urandom);
            e = inv_model(c);
            send_col(c, (n % 3 == 0) ? 0 : 2);
            recv(e, 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
